// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage is the master; the unit is the slave.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata_hi;
  logic [WIDTH-1:0] wdata_lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, hi_we, lo_we, wdata_hi, wdata_lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, hi_we, lo_we, wdata_hi, wdata_lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle.
// Define MDU_FAST_MUL_EN to compute products in a single cycle at accept time.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        resetn,
  mdu_iter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // MUL: {partial product upper, multiplier/product lower}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 last_step;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0]   fast_a, fast_b, fast_prod;
`endif

  always_comb begin
    is_signed = ~bus.op[0];
    a_neg     = is_signed & bus.src_a[WIDTH-1];
    b_neg     = is_signed & bus.src_b[WIDTH-1];
    mag_a     = a_neg ? -bus.src_a : bus.src_a;
    mag_b     = b_neg ? -bus.src_b : bus.src_b;
    last_step = (cnt_q == CntW'(WIDTH - 1));

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fix  = neg_res_q ? -mul_next : mul_next;

    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    // rem_shift never exceeds WIDTH bits when the trial subtract fails, so the restore fits
    if (!rem_diff[WIDTH]) begin
      div_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    quo_fix = div_zero_q ? '1 : (neg_res_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);
    // A zero divisor leaves |a| as remainder, so restoring the dividend sign yields raw src_a
    rem_fix = neg_rem_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
    fast_a    = {{WIDTH{a_neg}}, bus.src_a};
    fast_b    = {{WIDTH{b_neg}}, bus.src_b};
    fast_prod = fast_a * fast_b;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.cancel) begin
          cnt_d      = '0;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = bus.op[1] & (bus.src_b == '0);
          if (bus.op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            opnd_d  = mag_b;
            state_d = StDiv;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            opnd_d  = mag_a;
`ifdef MDU_FAST_MUL_EN
            {hi_d, lo_d} = fast_prod;
            state_d      = StDone;
`else
            state_d      = StMul;
`endif
          end
        end
      end
      StMul: begin
        if (bus.cancel) begin
          state_d = StIdle;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + CntW'(1);
          if (last_step) begin
            {hi_d, lo_d} = prod_fix;
            state_d      = StDone;
          end
        end
      end
      StDiv: begin
        if (bus.cancel) begin
          state_d = StIdle;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + CntW'(1);
          if (last_step) begin
            hi_d    = rem_fix;
            lo_d    = quo_fix;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // A same-cycle cancel suppresses the DONE write
  assign bus.busy     = (state_q != StIdle);
  assign bus.hi_we    = (state_q == StDone) & ~bus.cancel;
  assign bus.lo_we    = (state_q == StDone) & ~bus.cancel;
  assign bus.wdata_hi = hi_q;
  assign bus.wdata_lo = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: a cycle-level behavioural model (accept time, latency,
// cancel, reset) plus plain-arithmetic HI/LO results, checked every cycle.
module tb_mdu_iter;

  logic clk;
  logic resetn;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit pend = 1'b0;
  int strobe_at = 0;
  logic [31:0] exp_hi, exp_lo;
  int n_strobes = 0;
  logic [31:0] last_hi, last_lo;
  logic [31:0] specials [0:5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'h7FFF_FFFF, 32'h2};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Architectural results {hi, lo} from plain arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [1:0] op);
`ifdef MDU_FAST_MUL_EN
    if (!op[1]) return 1;
`endif
    return 33;
  endfunction

  // Model: track whether an op is in flight and when it must write
  always @(posedge clk) begin
    if (!resetn) pend <= 1'b0;
    else if (pend) begin
      if (bus.cancel || cyc == strobe_at) pend <= 1'b0;
    end else if (bus.start && !bus.cancel) begin
      pend      <= 1'b1;
      strobe_at <= cyc + latency(bus.op);
      {exp_hi, exp_lo} <= ref_result(bus.op, bus.src_a, bus.src_b);
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    logic ew;
    if (!resetn) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_we", {bus.hi_we, bus.lo_we}, 0);
      chk("rst_wdata", {bus.wdata_hi, bus.wdata_lo}, 0);
    end else begin
      ew = pend && (cyc == strobe_at) && !bus.cancel;
      chk("busy", bus.busy, pend);
      chk("hi_we", bus.hi_we, ew);
      chk("lo_we", bus.lo_we, ew);
      if (ew) begin
        chk("wdata_hi", bus.wdata_hi, exp_hi);
        chk("wdata_lo", bus.wdata_lo, exp_lo);
      end
      if (bus.hi_we) begin
        n_strobes++;
        last_hi = bus.wdata_hi;
        last_lo = bus.wdata_lo;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && pend; i++) step();
    if (pend) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l);
    int n0;
    wait_idle();
    n0 = n_strobes;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 60 && n_strobes == n0; i++) step();
    if (n_strobes == n0) chk("strobe_timeout", 1, 0);
    h = last_hi;
    l = last_lo;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) v = specials[$urandom_range(0, 5)];
    else if ($urandom_range(0, 3) == 0) v = 32'($urandom_range(0, 20));
    else v = $urandom;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] h, l;
    int n0;
    logic [1:0] rop;
    int r;

    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.cancel = 1'b0;
    #1;
    chk("reset_busy_t0", bus.busy, 0);
    repeat (3) step();
    resetn = 1'b1;
    step();

    run_op(2'b00, 32'hFFFF_FFFE, 32'h3, h, l);
    chk("t1_mult", {h, l}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l);
    chk("t2_multu", {h, l}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2, h, l);
    chk("t3_div_neg", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'h7, 32'h0, h, l);
    chk("t3_divu_zero", {h, l}, 64'h0000_0007_FFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0, h, l);
    chk("div_zero_signed", {h, l}, 64'hFFFF_FFF9_FFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
    chk("t4_div_ovf", {h, l}, 64'h0000_0000_8000_0000);
    run_op(2'b10, 32'h7, 32'hFFFF_FFFE, h, l);
    chk("div_rem_sign", {h, l}, 64'h0000_0001_FFFF_FFFD);

    // start together with cancel in IDLE is ignored
    wait_idle();
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b10;
    step();
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("start_cancel_idle", bus.busy, 0);

    // Cancel at N+10, restart at N+11
    wait_idle();
    n0 = n_strobes;
    bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    chk("t5_busy_after_cancel", bus.busy, 0);
    chk("t5_no_strobe", n_strobes, n0);
    run_op(2'b11, 32'd100, 32'd7, h, l);
    chk("t5_restart", {h, l}, {32'd2, 32'd14});

    // start re-asserted with other operands while busy
    wait_idle();
    bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd100; bus.src_b = 32'd7;
    step();
    n0 = n_strobes;
    bus.op = 2'b00; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9;
    repeat (10) step();
    bus.start = 1'b0;
    for (int i = 0; i < 60 && n_strobes == n0; i++) step();
    chk("t6_ignore_start", {last_hi, last_lo}, {32'd2, 32'd14});

    // Reset mid-DIV
    wait_idle();
    n0 = n_strobes;
    bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd77; bus.src_b = 32'd5;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    resetn = 1'b0;
    #1;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_wdata", {bus.wdata_hi, bus.wdata_lo}, 0);
    step();
    step();
    resetn = 1'b1;
    repeat (45) step();
    chk("t6_no_strobe_after_rst", n_strobes, n0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'h5, h, l);
    chk("after_rst_mult", {h, l}, 64'hFFFF_FFFF_FFFF_FFFB);

    // Randomized ops with ignored starts and occasional cancels while busy
    for (int t = 0; t < 80; t++) begin
      wait_idle();
      rop = 2'($urandom_range(0, 3));
      bus.start = 1'b1;
      bus.op    = rop;
      bus.src_a = pick();
      bus.src_b = ($urandom_range(0, 9) == 0) ? 32'h0 : pick();
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 45 && pend; i++) begin
        r = $urandom_range(0, 99);
        bus.start  = (r < 25);
        bus.op     = 2'($urandom_range(0, 3));
        bus.src_a  = $urandom;
        bus.src_b  = $urandom;
        bus.cancel = (r == 99);
        step();
      end
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
    end
    wait_idle();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
